mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 5 +
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared RAM handshake and arbiter state encodings
package cpu_types_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, DREQ, IREQ, RESP} arb_state_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter, data side has priority over instruction side.
// Ports: CLK/RST (async active-high); iREN/iaddr -> ihit/iload; dREN/dWEN/daddr/dstore -> dhit/dload;
//        ramREN/ramWEN/ramaddr/ramstore -> RAM, ramload/ramstate <- RAM; mem_err sticky abort flag.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        mem_err
);
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    arb_state_t  r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_store;
    logic        r_wen;
    logic        r_ihit;
    logic        r_dhit;
    logic [31:0] r_iload;
    logic [31:0] r_dload;
    logic        r_err;
    logic        w_dreq;
    logic        w_act;

    assign w_dreq   = dREN | dWEN;
    assign w_act    = (r_state == DREQ) || (r_state == IREQ);
    assign ramREN   = w_act & ~r_wen;
    assign ramWEN   = w_act & r_wen;
    assign ramaddr  = r_addr;
    assign ramstore = r_store;
    assign ihit     = r_ihit;
    assign dhit     = r_dhit;
    assign iload    = r_iload;
    assign dload    = r_dload;
    assign mem_err  = r_err;

    // The DREQ/IREQ state itself records which requester owns the transaction.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_store <= '0;
            r_wen   <= 1'b0;
            r_ihit  <= 1'b0;
            r_dhit  <= 1'b0;
            r_iload <= '0;
            r_dload <= '0;
            r_err   <= 1'b0;
        end else begin
            r_ihit <= 1'b0;
            r_dhit <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_dreq || iREN) begin
                        r_cnt   <= '0;
                        r_addr  <= w_dreq ? daddr : iaddr;
                        r_store <= w_dreq ? dstore : '0;
                        r_wen   <= w_dreq & dWEN;
                        r_state <= w_dreq ? DREQ : IREQ;
                    end
                end
                DREQ, IREQ: begin
                    if (ramstate == ACCESS) begin
                        // hit is raised here so it is visible for exactly the RESP cycle
                        r_dhit  <= (r_state == DREQ);
                        r_ihit  <= (r_state == IREQ);
                        r_state <= RESP;
                        if (r_state == DREQ && !r_wen) r_dload <= ramload;
                        if (r_state == IREQ) r_iload <= ramload;
                    end else if (ramstate == ERROR || r_cnt == LP_LAST) begin
                        // abort without a hit; a still-held request re-arbitrates from IDLE
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam logic [31:0] K = 32'h3401_0045;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
    logic        ihit, dhit, ramREN, ramWEN, mem_err;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    ramstate_t   ramstate = FREE;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    assign ramload = ramaddr ^ K;

    always #5 CLK = ~CLK;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ihit(ihit), .iload(iload), .dhit(dhit),
        .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge CLK);
        #1;
        chk("hit_exclusive", {31'd0, ihit & dhit}, 32'd0);
        if (ihit || dhit) begin
            if (sb.size() == 0) begin
                chk("unexpected_hit", {30'd0, ihit, dhit}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("hit_kind", {31'd0, dhit}, {31'd0, e.is_d});
                chk("hit_data", dhit ? dload : iload, e.data);
            end
        end
    endtask

    initial begin
        logic [31:0] old_dload;
        #1 RST = 1'b1;
        #1;
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_dhit", {31'd0, dhit}, 32'd0);
        chk("rst_err", {31'd0, mem_err}, 32'd0);
        chk("rst_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("rst_addr", ramaddr, 32'd0);
        chk("rst_loads", iload | dload, 32'd0);
        tick();
        tick();
        RST = 1'b0;

        // single instruction fetch, one BUSY cycle then ACCESS
        iREN = 1'b1; iaddr = 32'h0000_0040; ramstate = BUSY;
        push(1'b0, 32'h3401_0005);
        tick();
        chk("i_ren_wait", {31'd0, ramREN}, 32'd1);
        chk("i_addr", ramaddr, 32'h40);
        chk("i_wen", {31'd0, ramWEN}, 32'd0);
        tick();
        chk("i_ren_busy", {31'd0, ramREN}, 32'd1);
        chk("i_nohit_early", {31'd0, ihit}, 32'd0);
        ramstate = ACCESS;
        tick();
        chk("i_hit", {31'd0, ihit}, 32'd1);
        chk("i_ren_resp", {31'd0, ramREN}, 32'd0);
        iREN = 1'b0; ramstate = FREE;
        tick();
        chk("i_hit_once", {31'd0, ihit}, 32'd0);
        chk("i_load_hold", iload, 32'h3401_0005);
        chk("i_sb_empty", sb.size(), 32'd0);

        // simultaneous requests: data first, then instruction
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h80; ramstate = ACCESS;
        push(1'b1, 32'h80 ^ K);
        push(1'b0, 32'h44 ^ K);
        for (int i = 0; i < 20 && (iREN || dREN); i++) begin
            tick();
            if (dhit) dREN = 1'b0;
            if (ihit) iREN = 1'b0;
        end
        chk("arb_done", {30'd0, iREN, dREN}, 32'd0);
        chk("arb_sb_empty", sb.size(), 32'd0);
        ramstate = FREE;
        tick();

        // data write
        old_dload = 32'h80 ^ K;
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ramstate = BUSY;
        tick();
        chk("w_wen", {31'd0, ramWEN}, 32'd1);
        chk("w_ren", {31'd0, ramREN}, 32'd0);
        chk("w_addr", ramaddr, 32'h100);
        chk("w_store", ramstore, 32'hDEAD_BEEF);
        tick();
        chk("w_wen_busy", {31'd0, ramWEN}, 32'd1);
        ramstate = ACCESS;
        push(1'b1, old_dload);
        tick();
        chk("w_hit", {31'd0, dhit}, 32'd1);
        chk("w_dload_kept", dload, old_dload);
        dWEN = 1'b0; ramstate = FREE;
        tick();

        // instruction request withdrawn mid-transaction still completes
        iREN = 1'b1; iaddr = 32'h48; ramstate = BUSY;
        tick();
        iREN = 1'b0;
        tick();
        chk("wd_ren", {31'd0, ramREN}, 32'd1);
        ramstate = ACCESS;
        push(1'b0, 32'h48 ^ K);
        tick();
        chk("wd_hit", {31'd0, ihit}, 32'd1);
        ramstate = FREE;
        tick();
        chk("wd_sb_empty", sb.size(), 32'd0);

        // timeout abort after 4 wait cycles, then retry succeeds
        dREN = 1'b1; daddr = 32'h200; ramstate = BUSY;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_ren", {31'd0, ramREN}, 32'd1);
            chk("to_err_clear", {31'd0, mem_err}, 32'd0);
        end
        tick();
        chk("to_err_set", {31'd0, mem_err}, 32'd1);
        chk("to_ren_idle", {31'd0, ramREN}, 32'd0);
        chk("to_nohit", {31'd0, dhit}, 32'd0);
        tick();
        chk("to_retry_ren", {31'd0, ramREN}, 32'd1);
        chk("to_retry_addr", ramaddr, 32'h200);
        ramstate = ACCESS;
        push(1'b1, 32'h200 ^ K);
        tick();
        chk("to_retry_hit", {31'd0, dhit}, 32'd1);
        chk("to_err_sticky", {31'd0, mem_err}, 32'd1);
        dREN = 1'b0; ramstate = FREE;
        tick();

        // asynchronous reset in the middle of a data read
        dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
        tick();
        chk("ar_ren", {31'd0, ramREN}, 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("ar_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("ar_addr", ramaddr, 32'd0);
        chk("ar_err", {31'd0, mem_err}, 32'd0);
        chk("ar_loads", iload | dload, 32'd0);
        chk("ar_hits", {30'd0, ihit, dhit}, 32'd0);
        tick();
        RST = 1'b0; ramstate = ACCESS;
        tick();
        chk("ar_reserve_ren", {31'd0, ramREN}, 32'd1);
        push(1'b1, 32'h300 ^ K);
        tick();
        chk("ar_hit", {31'd0, dhit}, 32'd1);
        dREN = 1'b0; ramstate = FREE;
        tick();
        chk("ar_dload", dload, 32'h300 ^ K);
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
